// File: rtl/tick_gen_if.sv
// Control/status bundle between a tick_gen and whatever drives it.
// The controller side is the master; the rate generator itself is the slave.
interface tick_gen_if #(
    parameter int DIV_WIDTH = 8,
    parameter int REP_WIDTH = 4
);
    logic                 start;
    logic                 stop;
    logic                 oneshot;
    logic [REP_WIDTH-1:0] reps;
    logic [DIV_WIDTH-1:0] period;
    logic                 period_load;
    logic                 tick;
    logic                 busy;
    logic                 done;

    modport master (
        output start, stop, oneshot, reps, period, period_load,
        input  tick, busy, done
    );

    modport slave (
        input  start, stop, oneshot, reps, period, period_load,
        output tick, busy, done
    );
endinterface

// File: rtl/tick_gen.sv
// Programmable tick generator: one-cycle enable every period+1 clocks, either
// free-running or as a burst of reps+1 ticks, with period changes applied at tick boundaries.
module tick_gen #(
    parameter int DIV_WIDTH = 8,
    parameter int REP_WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    tick_gen_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               r_state,      w_state_nxt;
    logic [DIV_WIDTH-1:0] r_div_cnt,    w_div_cnt_nxt;
    logic [DIV_WIDTH-1:0] r_per_act,    w_per_act_nxt;
    logic [DIV_WIDTH-1:0] r_per_shadow, w_per_shadow_nxt;
    logic [REP_WIDTH-1:0] r_rep_cnt,    w_rep_cnt_nxt;
    logic                 r_mode_os,    w_mode_os_nxt;
    logic                 r_done,       w_done_nxt;
    logic                 w_tick;
    logic [DIV_WIDTH-1:0] w_per_src;

    // Tick is decoded purely from registers so the downstream counter sees a clean enable.
    assign w_tick    = (r_state == RUN) && (r_div_cnt == r_per_act);
    assign w_per_src = bus.period_load ? bus.period : r_per_shadow;

    assign bus.tick = w_tick;
    assign bus.busy = (r_state == RUN);
    assign bus.done = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_div_cnt    <= '0;
            r_per_act    <= '0;
            r_per_shadow <= '0;
            r_rep_cnt    <= '0;
            r_mode_os    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_div_cnt    <= w_div_cnt_nxt;
            r_per_act    <= w_per_act_nxt;
            r_per_shadow <= w_per_shadow_nxt;
            r_rep_cnt    <= w_rep_cnt_nxt;
            r_mode_os    <= w_mode_os_nxt;
            r_done       <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_div_cnt_nxt    = r_div_cnt;
        w_per_act_nxt    = r_per_act;
        w_per_shadow_nxt = bus.period_load ? bus.period : r_per_shadow;
        w_rep_cnt_nxt    = r_rep_cnt;
        w_mode_os_nxt    = r_mode_os;
        w_done_nxt       = 1'b0;

        case (r_state)
            IDLE: begin
                w_per_act_nxt = w_per_src;
                if (bus.start && !bus.stop) begin
                    w_state_nxt   = RUN;
                    w_div_cnt_nxt = '0;
                    w_mode_os_nxt = bus.oneshot;
                    w_rep_cnt_nxt = bus.reps;
                end
            end
            RUN: begin
                if (w_tick) begin
                    // Only a tick boundary may swap the period, so no interval is ever cut short.
                    w_div_cnt_nxt = '0;
                    w_per_act_nxt = w_per_src;
                    if (r_mode_os) begin
                        if (r_rep_cnt == '0) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_rep_cnt_nxt = r_rep_cnt - REP_WIDTH'(1);
                        end
                    end
                end else begin
                    w_div_cnt_nxt = r_div_cnt + DIV_WIDTH'(1);
                end
                if (bus.stop) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule

// File: doc/tick_gen.md
Name: tick_gen

Overview:
- Programmable rate generator that produces single-cycle enable pulses ("ticks") for the counter stage directly downstream; tick connects straight to the counter's en input.
- Supports free-running (periodic) and one-shot burst modes.
- Supports a glitch-free period update at tick boundaries and a start/stop handshake with busy/done status.

Parameters:
- DIV_WIDTH, 8, width of the period value; tick spacing is period+1 clock cycles.
- REP_WIDTH, 4, width of the one-shot repeat count; a burst is reps+1 ticks.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to begin generating ticks; sampled only in IDLE.
- stop  in  1  request to halt; sampled in RUN, and wins over start.
- oneshot  in  1  mode select, captured at start: 1 = burst, 0 = periodic.
- reps  in  REP_WIDTH  burst length minus 1, captured at start.
- period  in  DIV_WIDTH  new period value.
- period_load  in  1  write strobe for period.
- tick  out  1  one-cycle enable pulse.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse after the final burst tick.

Behaviour:
- Registers:
  - state: IDLE or RUN.
  - div_cnt: DIV_WIDTH bits.
  - rep_cnt: REP_WIDTH bits.
  - per_act and per_shadow: DIV_WIDTH bits each.
  - mode_os: 1 bit.
  - done_r: 1 bit.
- Reset:
  - state = IDLE; div_cnt, rep_cnt, per_act, per_shadow and mode_os = 0.
  - tick = 0, busy = 0, done = 0.
  - rst asserted mid-RUN returns to all reset values at the next edge; there is no done pulse and no tick in the following cycle.
- Outputs:
  - tick = (state==RUN) && (div_cnt==per_act), decoded from registers only.
  - busy = (state==RUN).
  - done = done_r, which is registered.
- Period update:
  - period_load=1 writes per_shadow <= period in any state.
  - In IDLE: per_act <= per_shadow every cycle. If period_load is high in that cycle, the incoming period is used directly.
  - In RUN: per_act updates only on an edge where tick=1, from per_shadow (or from period if period_load is high in the same cycle). The in-progress interval is never altered.
- IDLE -> RUN:
  - Condition: start=1 && stop=0.
  - Actions: div_cnt <= 0; mode_os <= oneshot; rep_cnt <= reps.
  - Latency: start sampled at edge N gives the first tick in cycle N+1+P, where P = per_act in effect at entry. Subsequent ticks follow every P+1 cycles.
  - P=0 gives tick=1 in every RUN cycle.
- RUN counting:
  - If tick=1: div_cnt <= 0. Otherwise div_cnt <= div_cnt+1.
  - div_cnt never exceeds per_act, so no wrap-around beyond the period.
- Burst termination (mode_os=1):
  - On each tick with rep_cnt != 0: rep_cnt decrements.
  - On a tick with rep_cnt==0: state <= IDLE and done_r <= 1 for exactly one cycle.
  - busy falls in the same cycle that done is high.
  - Total ticks in a burst = reps+1.
- Periodic mode (mode_os=0): ticks continue until stop; rep_cnt is ignored.
- stop in RUN:
  - state <= IDLE at the next edge with no done pulse.
  - A tick decoded in the same cycle as stop is still asserted.
  - No tick occurs after that cycle.
- start in RUN is ignored; mode and reps are not recaptured.
- start in IDLE with stop=1 is ignored.
- start in the cycle where done=1 is accepted, because state is already IDLE. This allows back-to-back bursts with one idle cycle.
- Simultaneous final burst tick and stop: go to IDLE; done is still pulsed because the burst completed.
- done_r clears in every cycle except the one following burst completion.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0, start=0 -> tick, busy and done stay 0 for 20 cycles.
- Periodic timing: period=4 loaded in IDLE, start pulse at edge N -> busy=1 from cycle N+1; tick in cycles N+5, N+10, N+15; after stop, tick stays 0 and busy=0 with no done; a counter with COUNT_WIDTH=3 driven by tick advances by 1 per tick.
- One-shot burst: period=2, oneshot=1, reps=3 -> exactly 4 ticks spaced 3 cycles apart; done=1 for one cycle immediately after the 4th tick, coinciding with busy=0.
- Divide-by-1: period=0, periodic mode -> tick=1 on every RUN cycle; stop in cycle M -> tick=1 in cycle M and 0 from cycle M+1.
- Boundary-aligned period change: period=5 running, period_load with period=1 mid-interval -> the current interval completes at 6 cycles, after which intervals are 2 cycles; period_load coincident with a tick takes effect immediately for the next interval.
- Mid-operation reset and races: rst during a burst -> all outputs 0 next cycle and no done; start+stop together in IDLE -> stays IDLE; start during the done cycle -> new burst starts with its first tick P+1 cycles later.
